// File: rtl/fll_pkg.sv
// -----------------------------------------------------------------------------
// fll_pkg
// Shared types and helpers for the FLL DCO tuning controller.
//   fll_state_e   : controller FSM states (IDLE, REQ, EVAL, SETTLE)
//   fll_phase_e   : search phase (coarse binary search or +/-1 tracking)
//   fll_mid_code  : mid-scale DCO code for a given code width
// No ports.
// -----------------------------------------------------------------------------
package fll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_EVAL   = 2'd2,
      ST_SETTLE = 2'd3
   } fll_state_e;

   typedef enum logic {
      PH_SAR   = 1'b0,
      PH_TRACK = 1'b1
   } fll_phase_e;

   // Mid-scale code 2^(code_w-1): the starting point of both the binary
   // search and the tracking loop.
   function automatic int unsigned fll_mid_code(input int unsigned code_w);
      return 32'd1 << (code_w - 1);
   endfunction

endpackage : fll_pkg

// File: rtl/fll_dco_ctrl_if.sv
// -----------------------------------------------------------------------------
// fll_dco_ctrl_if
// Measurement handshake between the DCO controller and the cross-domain
// frequency counter. All signals live in the ref_clk domain.
//   meas_req   : level request for a measurement (controller -> counter)
//   meas_done  : single-cycle completion pulse (counter -> controller)
//   meas_count : DCO-divided-clock count, valid with meas_done
// Modports: master = controller, slave = counter block.
// -----------------------------------------------------------------------------
interface fll_dco_ctrl_if #(
   parameter int CountW = 11
) ();

   logic              meas_req;
   logic              meas_done;
   logic [CountW-1:0] meas_count;

   modport master (
      output meas_req,
      input  meas_done,
      input  meas_count
   );

   modport slave (
      input  meas_req,
      output meas_done,
      output meas_count
   );

endinterface : fll_dco_ctrl_if

// File: rtl/fll_settle_timer.sv
// -----------------------------------------------------------------------------
// fll_settle_timer
// Loadable down-counter used to let the DCO settle after a code change.
// Ports:
//   ref_clk  in   clock
//   reset    in   synchronous active-high reset
//   i_load   in   load i_value into the counter
//   i_value  in   SettleW  load value
//   i_run    in   count down while high (stops at zero)
//   o_done   out  counter is at zero
// A load of N followed by i_run yields o_done after N cycles, so a wait state
// that exits on o_done lasts N+1 cycles.
// -----------------------------------------------------------------------------
module fll_settle_timer #(
   parameter int SettleW = 8
) (
   input  logic               ref_clk,
   input  logic               reset,
   input  logic               i_load,
   input  logic [SettleW-1:0] i_value,
   input  logic               i_run,
   output logic               o_done
);

   logic [SettleW-1:0] r_cnt;

   always_ff @(posedge ref_clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (i_run && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = (r_cnt == '0);

endmodule : fll_settle_timer

// File: rtl/fll_dco_ctrl.sv
// -----------------------------------------------------------------------------
// fll_dco_ctrl
// Closed-loop DCO tuning controller for the LC-DCO FLL (ref_clk domain).
// Requests a frequency measurement, compares the returned count against the
// target and adjusts the DCO code: optional coarse binary search (SAR), then
// +/-1 tracking. Lock is reported after LockCount consecutive in-range
// tracking measurements.
//
// Build option: define FLL_SAR_EN to compile the binary-search phase. Without
// it the controller always tracks, starting from the mid-scale code.
//
// Ports:
//   ref_clk         in   clock
//   reset           in   synchronous active-high reset
//   enable          in   loop enable (level)
//   target_count    in   CountW   desired count per measurement window
//   lock_range      in   CountW   allowed |error| for in-range
//   settle_cycles   in   SettleW  wait after each evaluation (+1 cycle)
//   meas            if   master modport: meas_req / meas_done / meas_count
//   dco_code        out  CodeW    DCO tuning code (higher = faster)
//   code_update     out  pulse in the first cycle dco_code shows a new value
//   freq_incr_decr  out  1 = last error positive (DCO too slow)
//   freq_err        out  CountW+1 last target_count - meas_count (2's compl.)
//   fll_locked      out  lock indicator
// -----------------------------------------------------------------------------
module fll_dco_ctrl
   import fll_pkg::*;
#(
   parameter int CountW    = 11,
   parameter int CodeW     = 8,
   parameter int SettleW   = 8,
   parameter int LockCount = 4
) (
   input  logic               ref_clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [CountW-1:0]  target_count,
   input  logic [CountW-1:0]  lock_range,
   input  logic [SettleW-1:0] settle_cycles,
   fll_dco_ctrl_if.master     meas,
   output logic [CodeW-1:0]   dco_code,
   output logic               code_update,
   output logic               freq_incr_decr,
   output logic [CountW:0]    freq_err,
   output logic               fll_locked
);

   localparam logic [CodeW-1:0] MID      = CodeW'(fll_mid_code(CodeW));
   localparam logic [CodeW-1:0] CODE_MAX = '1;
   localparam int               LockW    = 4;
   localparam logic [LockW-1:0] LOCK_TGT = LockW'(LockCount);

   // ---------------------------------------------------------------- state
   fll_state_e          r_state, w_state_next;
   logic                r_meas_req, w_meas_req_next;
   logic [CountW-1:0]   r_meas_cnt, w_meas_cnt_next;
   logic [CodeW-1:0]    r_dco_code, w_code_next;
   logic                r_code_update, w_code_update_next;
   logic [CountW:0]     r_freq_err, w_freq_err_next;
   logic                r_incr, w_incr_next;
   logic                r_locked, w_locked_next;
   logic [LockW-1:0]    r_lock_cnt, w_lock_cnt_next;

`ifdef FLL_SAR_EN
   localparam int             SarW    = (CodeW > 1) ? $clog2(CodeW) : 1;
   localparam logic [SarW-1:0] SAR_TOP = SarW'(CodeW - 1);

   fll_phase_e      r_phase, w_phase_next;
   logic [SarW-1:0] r_sar_bit, w_sar_bit_next;
   logic [CodeW-1:0] w_sar_code;
`endif

   // ---------------------------------------------------------------- error
   // Error is formed in CountW+1 bits so target - count never overflows;
   // the MSB is the sign.
   logic [CountW:0] w_err;
   logic            w_err_neg;
   logic            w_err_pos;
   logic [CountW:0] w_err_abs;
   logic            w_in_range;

   assign w_err      = {1'b0, target_count} - {1'b0, r_meas_cnt};
   assign w_err_neg  = w_err[CountW];
   assign w_err_pos  = !w_err_neg && (w_err != '0);
   assign w_err_abs  = w_err_neg ? (~w_err + 1'b1) : w_err;
   assign w_in_range = (w_err_abs <= {1'b0, lock_range});

   // ---------------------------------------------------------------- settle
   logic w_settle_load;
   logic w_settle_run;
   logic w_settle_done;

   assign w_settle_run = (r_state == ST_SETTLE);

   fll_settle_timer #(
      .SettleW (SettleW)
   ) u_settle (
      .ref_clk (ref_clk),
      .reset   (reset),
      .i_load  (w_settle_load),
      .i_value (settle_cycles),
      .i_run   (w_settle_run),
      .o_done  (w_settle_done)
   );

   // ---------------------------------------------------------------- registers
   always_ff @(posedge ref_clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_meas_req    <= 1'b0;
         r_meas_cnt    <= '0;
         r_dco_code    <= MID;
         r_code_update <= 1'b0;
         r_freq_err    <= '0;
         r_incr        <= 1'b0;
         r_locked      <= 1'b0;
         r_lock_cnt    <= '0;
`ifdef FLL_SAR_EN
         r_phase       <= PH_SAR;
         r_sar_bit     <= SAR_TOP;
`endif
      end else begin
         r_state       <= w_state_next;
         r_meas_req    <= w_meas_req_next;
         r_meas_cnt    <= w_meas_cnt_next;
         r_dco_code    <= w_code_next;
         r_code_update <= w_code_update_next;
         r_freq_err    <= w_freq_err_next;
         r_incr        <= w_incr_next;
         r_locked      <= w_locked_next;
         r_lock_cnt    <= w_lock_cnt_next;
`ifdef FLL_SAR_EN
         r_phase       <= w_phase_next;
         r_sar_bit     <= w_sar_bit_next;
`endif
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_next    = r_state;
      w_meas_req_next = r_meas_req;
      w_meas_cnt_next = r_meas_cnt;
      w_code_next     = r_dco_code;
      w_freq_err_next = r_freq_err;
      w_incr_next     = r_incr;
      w_locked_next   = r_locked;
      w_lock_cnt_next = r_lock_cnt;
      w_settle_load   = 1'b0;
`ifdef FLL_SAR_EN
      w_phase_next    = r_phase;
      w_sar_bit_next  = r_sar_bit;
      w_sar_code      = r_dco_code;
`endif

      if (!enable) begin
         // Abort from any state; the code is kept so the DCO stays put.
         w_state_next    = ST_IDLE;
         w_meas_req_next = 1'b0;
         w_locked_next   = 1'b0;
         w_lock_cnt_next = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Every (re)start begins from mid-scale at the top of the search.
               w_state_next    = ST_REQ;
               w_meas_req_next = 1'b1;
               w_code_next     = MID;
`ifdef FLL_SAR_EN
               w_phase_next    = PH_SAR;
               w_sar_bit_next  = SAR_TOP;
`endif
            end

            ST_REQ: begin
               if (meas.meas_done) begin
                  w_meas_cnt_next = meas.meas_count;
                  w_meas_req_next = 1'b0;
                  w_state_next    = ST_EVAL;
               end
            end

            ST_EVAL: begin
               w_freq_err_next = w_err;
               w_incr_next     = w_err_pos;
               w_settle_load   = 1'b1;
               w_state_next    = ST_SETTLE;
`ifdef FLL_SAR_EN
               if (r_phase == PH_SAR) begin
                  // Trial bit stays only if the DCO was not too fast.
                  if (w_err_neg) begin
                     w_sar_code[r_sar_bit] = 1'b0;
                  end
                  if (r_sar_bit != '0) begin
                     w_sar_code[r_sar_bit - 1'b1] = 1'b1;
                     w_sar_bit_next = r_sar_bit - 1'b1;
                  end else begin
                     w_phase_next = PH_TRACK;
                  end
                  w_code_next     = w_sar_code;
                  w_lock_cnt_next = '0;
                  w_locked_next   = 1'b0;
               end else
`endif
               begin
                  if (w_in_range) begin
                     w_lock_cnt_next = (r_lock_cnt >= LOCK_TGT) ? r_lock_cnt
                                                                : r_lock_cnt + 1'b1;
                     w_locked_next   = (w_lock_cnt_next >= LOCK_TGT);
                  end else begin
                     if (w_err_pos && (r_dco_code != CODE_MAX)) begin
                        w_code_next = r_dco_code + 1'b1;
                     end else if (w_err_neg && (r_dco_code != '0)) begin
                        w_code_next = r_dco_code - 1'b1;
                     end
                     w_lock_cnt_next = '0;
                     w_locked_next   = 1'b0;
                  end
               end
            end

            ST_SETTLE: begin
               if (w_settle_done) begin
                  w_state_next    = ST_REQ;
                  w_meas_req_next = 1'b1;
               end
            end

            default: begin
               w_state_next    = ST_IDLE;
               w_meas_req_next = 1'b0;
            end
         endcase
      end

      // Pulse only when the code really moves (saturation gives no pulse).
      w_code_update_next = (w_code_next != r_dco_code);
   end

   // ---------------------------------------------------------------- outputs
   assign meas.meas_req   = r_meas_req;
   assign dco_code        = r_dco_code;
   assign code_update     = r_code_update;
   assign freq_incr_decr  = r_incr;
   assign freq_err        = r_freq_err;
   assign fll_locked      = r_locked;

endmodule : fll_dco_ctrl

// File: tb/tb_fll_dco_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fll_dco_ctrl
// Directed bench for fll_dco_ctrl (CodeW=8, CountW=11, LockCount=4).
// DCO model: meas_count = 4*dco_code + offset, meas_done 20 cycles after
// meas_req rises. Honours FLL_SAR_EN to select the expected code sequence.
// -----------------------------------------------------------------------------
module tb_fll_dco_ctrl;

   localparam int CountW    = 11;
   localparam int CodeW     = 8;
   localparam int SettleW   = 8;
   localparam int LockCount = 4;

   logic               ref_clk;
   logic               reset;
   logic               enable;
   logic [CountW-1:0]  target_count;
   logic [CountW-1:0]  lock_range;
   logic [SettleW-1:0] settle_cycles;
   logic [CodeW-1:0]   dco_code;
   logic               code_update;
   logic               freq_incr_decr;
   logic [CountW:0]    freq_err;
   logic               fll_locked;

   int n_checks = 0;
   int n_fail   = 0;
   int n_eval   = 0;
   int offset   = 0;

   fll_dco_ctrl_if #(.CountW(CountW)) meas_if ();

   fll_dco_ctrl #(
      .CountW    (CountW),
      .CodeW     (CodeW),
      .SettleW   (SettleW),
      .LockCount (LockCount)
   ) dut (
      .ref_clk        (ref_clk),
      .reset          (reset),
      .enable         (enable),
      .target_count   (target_count),
      .lock_range     (lock_range),
      .settle_cycles  (settle_cycles),
      .meas           (meas_if),
      .dco_code       (dco_code),
      .code_update    (code_update),
      .freq_incr_decr (freq_incr_decr),
      .freq_err       (freq_err),
      .fll_locked     (fll_locked)
   );

   initial begin
      ref_clk = 1'b0;
      forever #5 ref_clk = ~ref_clk;
   end

   // DCO + counter model.
   initial begin
      meas_if.meas_done  = 1'b0;
      meas_if.meas_count = '0;
      forever begin
         @(posedge ref_clk);
         #1;
         if (meas_if.meas_req) begin
            repeat (20) @(posedge ref_clk);
            #1;
            meas_if.meas_count = 11'(4 * int'(dco_code) + offset);
            meas_if.meas_done  = 1'b1;
            @(posedge ref_clk);
            #1;
            meas_if.meas_done  = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits for the next meas_done, then returns in the cycle the evaluation
   // result becomes visible (one cycle after the EVAL cycle).
   task automatic next_eval();
      bit seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge ref_clk);
         if (meas_if.meas_done) begin
            seen = 1'b1;
            break;
         end
      end
      check_val("meas_done_seen", 32'(seen), 32'd1);
      @(negedge ref_clk);
      check_val("req_fall", 32'(meas_if.meas_req), 32'd0);
      @(negedge ref_clk);
      n_eval++;
      $display("eval %0d: code=0x%02h upd=%0b err=%0d incr=%0b lock=%0b",
               n_eval, dco_code, code_update, $signed(freq_err), freq_incr_decr, fll_locked);
   endtask

   // Counts meas_req-low cycles between a meas_done and the next request.
   task automatic measure_gap(output int gap);
      bit seen = 1'b0;
      gap = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge ref_clk);
         if (meas_if.meas_done) begin
            seen = 1'b1;
            break;
         end
      end
      check_val("gap_done_seen", 32'(seen), 32'd1);
      for (int i = 0; i < 50; i++) begin
         @(negedge ref_clk);
         if (meas_if.meas_req) break;
         gap++;
      end
      $display("gap: settle=%0d req_low_cycles=%0d", settle_cycles, gap);
   endtask

`ifdef FLL_SAR_EN
   logic [7:0] sar_exp [8] = '{8'h40, 8'h60, 8'h70, 8'h68, 8'h64, 8'h66, 8'h65, 8'h64};
`endif
   logic [7:0]  dis_code [4] = '{8'h62, 8'h61, 8'h60, 8'h5F};
   logic [11:0] dis_err  [4] = '{12'hFF0, 12'hFF4, 12'hFF8, 12'hFFC};

   initial begin
      int gap;
      bit done_seen;
      bit upd_seen;

      reset         = 1'b1;
      enable        = 1'b0;
      target_count  = 11'd400;
      lock_range    = 11'd2;
      settle_cycles = 8'd0;

      // ---------------- reset
      repeat (3) @(posedge ref_clk);
      #1 reset = 1'b0;
      @(negedge ref_clk);
      check_val("rst_code",   32'(dco_code),       32'h80);
      check_val("rst_upd",    32'(code_update),    32'd0);
      check_val("rst_err",    32'(freq_err),       32'd0);
      check_val("rst_incr",   32'(freq_incr_decr), 32'd0);
      check_val("rst_lock",   32'(fll_locked),     32'd0);
      check_val("rst_req",    32'(meas_if.meas_req), 32'd0);

      // ---------------- abort mid-REQ
      enable = 1'b1;
      @(negedge ref_clk);
      check_val("req_rise", 32'(meas_if.meas_req), 32'd1);
      repeat (5) @(negedge ref_clk);
      enable = 1'b0;
      @(negedge ref_clk);
      check_val("abort_req_drop", 32'(meas_if.meas_req), 32'd0);
      done_seen = 1'b0;
      upd_seen  = 1'b0;
      repeat (30) begin
         @(negedge ref_clk);
         if (meas_if.meas_done) done_seen = 1'b1;
         if (code_update) upd_seen = 1'b1;
      end
      $display("abort: late_done=%0b code=0x%02h req=%0b", done_seen, dco_code, meas_if.meas_req);
      check_val("abort_late_done", 32'(done_seen), 32'd1);
      check_val("abort_no_update", 32'(upd_seen), 32'd0);
      check_val("abort_code", 32'(dco_code), 32'h80);
      check_val("abort_req_idle", 32'(meas_if.meas_req), 32'd0);

      // ---------------- acquisition
      enable = 1'b1;
`ifdef FLL_SAR_EN
      for (int i = 0; i < 8; i++) begin
         next_eval();
         check_val("sar_code", 32'(dco_code), 32'(sar_exp[i]));
         check_val("sar_upd", 32'(code_update), 32'd1);
         check_val("sar_lock", 32'(fll_locked), 32'd0);
         if (i == 0) begin
            check_val("sar_err0", 32'(freq_err), 32'hF90);
            check_val("sar_incr0", 32'(freq_incr_decr), 32'd0);
         end
         if (i == 1) begin
            check_val("sar_err1", 32'(freq_err), 32'h090);
            check_val("sar_incr1", 32'(freq_incr_decr), 32'd1);
         end
      end
`else
      for (int i = 1; i <= 28; i++) begin
         next_eval();
         check_val("trk_code", 32'(dco_code), 32'(128 - i));
         check_val("trk_upd", 32'(code_update), 32'd1);
         check_val("trk_lock", 32'(fll_locked), 32'd0);
         if (i == 1) begin
            check_val("trk_err0", 32'(freq_err), 32'hF90);
            check_val("trk_incr0", 32'(freq_incr_decr), 32'd0);
         end
         if (i == 28) check_val("trk_err_last", 32'(freq_err), 32'hFFC);
      end
`endif

      // ---------------- lock after 4 in-range evaluations
      for (int i = 1; i <= 4; i++) begin
         next_eval();
         check_val("lock_code", 32'(dco_code), 32'h64);
         check_val("lock_upd", 32'(code_update), 32'd0);
         check_val("lock_err", 32'(freq_err), 32'd0);
         check_val("lock_flag", 32'(fll_locked), 32'(i == 4));
      end

      // ---------------- disturbance: +20 counts
      offset = 20;
      next_eval();
      check_val("dis_lock_drop", 32'(fll_locked), 32'd0);
      check_val("dis_code0", 32'(dco_code), 32'h63);
      check_val("dis_err0", 32'(freq_err), 32'hFEC);
      check_val("dis_upd0", 32'(code_update), 32'd1);
      check_val("dis_incr0", 32'(freq_incr_decr), 32'd0);
      for (int i = 0; i < 4; i++) begin
         next_eval();
         check_val("dis_code", 32'(dco_code), 32'(dis_code[i]));
         check_val("dis_err", 32'(freq_err), 32'(dis_err[i]));
         check_val("dis_upd", 32'(code_update), 32'd1);
      end
      next_eval();
      check_val("dis_settled_code", 32'(dco_code), 32'h5F);
      check_val("dis_settled_upd", 32'(code_update), 32'd0);

      // ---------------- settle timing
      measure_gap(gap);
      check_val("gap_settle0", 32'(gap), 32'd2);
      settle_cycles = 8'd5;
      measure_gap(gap);
      check_val("gap_settle5", 32'(gap), 32'd7);
      settle_cycles = 8'd0;

      // ---------------- saturation at the top code
      offset       = 0;
      target_count = 11'd2047;
      for (int i = 0; i < 200; i++) begin
         next_eval();
         if (dco_code == 8'hFF) break;
      end
      check_val("sat_reached", 32'(dco_code), 32'hFF);
      for (int i = 0; i < 2; i++) begin
         next_eval();
         check_val("sat_code", 32'(dco_code), 32'hFF);
         check_val("sat_upd", 32'(code_update), 32'd0);
         check_val("sat_incr", 32'(freq_incr_decr), 32'd1);
         check_val("sat_lock", 32'(fll_locked), 32'd0);
         check_val("sat_err", 32'(freq_err), 32'h403);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fll_dco_ctrl
